spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 3, synchronizer depth for all SPI inputs.
REQ-002 Parameter CLK_RATIO_MIN, default 8, minimum clk/spi_sck frequency ratio; documentation only.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_sck  input  1  MCU SPI clock, mode 0, asynchronous to clk.
REQ-006 spi_cs_n  input  1  MCU chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  MCU data in, MSB first.
REQ-008 spi_miso  output  1  data to MCU, MSB first.
REQ-009 wr_reg  output  32  last written register value, feeds the mapper mux.
REQ-010 wr_reg_addr  output  4  address of the last write.
REQ-011 wr_reg_changed  output  1  toggles once per completed write.
REQ-012 rd_reg  input  32  status word from the mapper mux (loader buttons).
REQ-013 fpga_irq  input  1  interrupt request from the mapper mux.
REQ-014 mcu_irq  output  1  fpga_irq synchronized to clk.

Function
REQ-015 spi_sck, spi_cs_n, spi_mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the two oldest stages.
REQ-016 Frame = spi_cs_n low period; 8-bit command then 32 data bits; command bit7 = 1 write, 0 read; bits6:4 reserved; bits3:0 address.
REQ-017 FSM states IDLE, CMD, DATA, DONE; IDLE->CMD on synchronized cs_n falling; CMD->DATA after 8th sck rise; DATA->DONE after 40th rise; any state->IDLE on cs_n rising.
REQ-018 mosi SHALL be sampled on synchronized sck rising; miso SHALL change only on synchronized sck falling.
REQ-019 Read: on 8th sck rise, a 32-bit snapshot SHALL be latched: addr 0 -> rd_reg, addr 15 -> BRIDGE_ID, others -> 0; snapshot shifted out MSB first during bits 8..39.
REQ-020 miso SHALL be 0 during command bits, in DONE, in IDLE, and for write frames.
REQ-021 Write: on the clk cycle after the 40th sck rise is detected, wr_reg and wr_reg_addr SHALL update and wr_reg_changed SHALL toggle in that same cycle.
REQ-022 wr_reg/wr_reg_addr SHALL be stable at least until the next write completes (consumer samples after a 3-flop toggle sync).
REQ-023 Reserved bits nonzero: frame ignored entirely, no write, miso 0.
REQ-024 cs_n rising before bit 40: partial frame discarded, outputs unchanged, bit counter cleared.
REQ-025 Bits after the 40th in one frame SHALL be ignored; exactly one write per frame.
REQ-026 New cs_n falling in the same clk cycle as a completed write's update SHALL still be honoured (commit uses latched shift data).
REQ-027 mcu_irq SHALL equal fpga_irq delayed by two clk flops.

Reset
REQ-028 reset_n low SHALL asynchronously force: FSM IDLE, bit counter 0, shift registers 0, wr_reg 0, wr_reg_addr 0, wr_reg_changed 0, spi_miso 0, mcu_irq 0, synchronizers to idle (sck 0, cs_n 1).
REQ-029 Reset mid-frame SHALL discard the frame; after release, the bridge SHALL wait for a fresh cs_n falling edge.

Structure
REQ-030 Shared package SHALL hold REG_MAPPER=0, REG_LOADER=1, REG_STATUS=0, REG_ID=15, BRIDGE_ID=32'hFCA7_0001, and the FSM state enum.
REQ-031 One sub-module spi_sync (parameterized-depth single-bit synchronizer with reset value) SHALL be instantiated per asynchronous input.

Verification
REQ-032 Write cmd 0x80, data 0x0000_0A41, clk = 10x sck -> wr_reg 0x0000_0A41, wr_reg_addr 0, wr_reg_changed 0->1 exactly once.
REQ-033 rd_reg 0x0000_0005, read cmd 0x00 -> MCU receives 0x0000_0005; read cmd 0x0F -> 0xFCA7_0001; cmd 0x03 -> 0.
REQ-034 Write cmd 0x81, cs_n raised after 20 bits -> wr_reg, addr, changed unchanged; next full write 0x81/0x3 -> wr_reg 3, addr 1, changed toggles.
REQ-035 Write cmd 0x90 (reserved bit set), full frame -> no output change, miso 0 throughout.
REQ-036 reset_n low at bit 30 of a write then released, new full write 0x80/0x1234 -> only second write visible; wr_reg 0x1234, single toggle from 0.
REQ-037 Back-to-back frames (cs_n high one sck period) writing 0x1 then 0x2 -> wr_reg_changed toggles twice, final wr_reg 0x2; fpga_irq pulse -> mcu_irq follows 2 clk later.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the MCU-to-FPGA SPI register bridge: the register
// map, the bridge identification word, frame geometry and the FSM state type.
package spi_reg_bridge_pkg;

  // Register map as seen from the MCU side.
  localparam logic [3:0] REG_MAPPER = 4'd0;
  localparam logic [3:0] REG_LOADER = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd0;
  localparam logic [3:0] REG_ID     = 4'd15;

  // Constant returned when the MCU reads the identification register.
  localparam logic [31:0] BRIDGE_ID = 32'hFCA7_0001;

  // Frame geometry: an 8-bit command followed by a 32-bit data word.
  localparam int CMD_BITS   = 8;
  localparam int FRAME_BITS = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  // Word the MCU receives for a read of the given address.
  function automatic logic [31:0] read_snapshot(input logic [3:0] addr,
                                                input logic [31:0] status);
    logic [31:0] word;
    word = '0;
    if (addr == REG_STATUS) begin
      word = status;
    end else if (addr == REG_ID) begin
      word = BRIDGE_ID;
    end
    return word;
  endfunction

  // A command is only acted on when its reserved field is all zero.
  function automatic logic cmd_reserved_ok(input logic [7:0] cmd);
    return (cmd[6:4] == 3'b000);
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI pin bundle between the MCU (master) and the register bridge (slave).
interface spi_reg_bridge_if;

  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/spi_reg_bridge_sync.sv
// Parameterized-depth single-bit synchronizer with a selectable reset value.
// Exposes the oldest stage and the one just before it so the user can detect
// edges without adding another flop.
module spi_sync #(
  parameter int   STAGES    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic sync_prev
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain, idling at RESET_VAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out  = chain[STAGES-1];
  assign sync_prev = chain[STAGES-2];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that lets the MCU write a 32-bit register (with a 4-bit
// address) into the FPGA fabric and read back a status snapshot. Every SPI
// pin is oversampled in the clk domain; the bridge never runs logic on sck.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int SYNC_STAGES   = 3,
  parameter int CLK_RATIO_MIN = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_reg_bridge_if.slave   spi,
  output logic [31:0]       wr_reg,
  output logic [3:0]        wr_reg_addr,
  output logic              wr_reg_changed,
  input  logic [31:0]       rd_reg,
  input  logic              fpga_irq,
  output logic              mcu_irq
);

  // Edge detection needs two synchronizer taps, and each sck half period
  // must span several clk cycles for those taps to see it.
  if (SYNC_STAGES < 2 || CLK_RATIO_MIN < 4) begin : g_param_check
    $error("spi_reg_bridge: SYNC_STAGES must be >= 2 and CLK_RATIO_MIN >= 4");
  end

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic sck_old, sck_prev;
  logic cs_old, cs_prev;
  logic mosi_old, mosi_prev_unused;
  logic irq_prev_unused;

  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [FLUSH_W-1:0] flush_cnt;
  logic               flush_done;
  logic               armed;

  bridge_state_t state, state_next;

  logic [5:0]  bit_cnt;
  logic [7:0]  cmd_shift;
  logic [31:0] data_shift;
  logic [7:0]  cmd_word_next;
  logic        frame_write;

  logic [31:0] tx_shift;
  logic        tx_active;
  logic        miso_q;

  logic [31:0] commit_data;
  logic [3:0]  commit_addr;
  logic        commit_pending;

  logic frame_start, frame_end;
  logic cmd_shift_en, data_shift_en;
  logic snapshot_load, write_capture;
  logic tx_step, miso_clear;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (spi.spi_sck),
    .sync_out  (sck_old),
    .sync_prev (sck_prev)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (spi.spi_cs_n),
    .sync_out  (cs_old),
    .sync_prev (cs_prev)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (spi.spi_mosi),
    .sync_out  (mosi_old),
    .sync_prev (mosi_prev_unused)
  );

  spi_sync #(.STAGES(2), .RESET_VAL(1'b0)) u_sync_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (fpga_irq),
    .sync_out  (mcu_irq),
    .sync_prev (irq_prev_unused)
  );

  // Edges come from the two oldest synchronizer stages. mosi is taken from
  // its oldest stage, which lines up with the pre-edge sck sample.
  assign sck_rise = sck_prev & ~sck_old;
  assign sck_fall = ~sck_prev & sck_old;
  assign cs_rise  = cs_prev & ~cs_old;
  assign cs_fall  = ~cs_prev & cs_old & armed;

  assign flush_done    = (flush_cnt == FLUSH_W'(SYNC_STAGES));
  assign cmd_word_next = {cmd_shift[6:0], mosi_old};
  assign frame_write   = cmd_shift[7] & cmd_reserved_ok(cmd_shift);

  // After reset, let the synchronizers flush and only accept a frame start
  // once cs_n has been seen idle high, so a frame cut by reset is not resumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (!flush_done) begin
        flush_cnt <= flush_cnt + FLUSH_W'(1);
      end
      if (flush_done && cs_prev && cs_old) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_next    = state;
    frame_start   = 1'b0;
    frame_end     = 1'b0;
    cmd_shift_en  = 1'b0;
    data_shift_en = 1'b0;
    snapshot_load = 1'b0;
    write_capture = 1'b0;
    tx_step       = 1'b0;
    miso_clear    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next  = CMD;
          frame_start = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else if (sck_rise) begin
          cmd_shift_en = 1'b1;
          if (bit_cnt == 6'(CMD_BITS - 1)) begin
            state_next    = DATA;
            snapshot_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          if (sck_rise) begin
            data_shift_en = 1'b1;
            if (bit_cnt == 6'(FRAME_BITS - 1)) begin
              state_next    = DONE;
              write_capture = frame_write;
            end
          end
          if (sck_fall) begin
            tx_step = 1'b1;
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else if (sck_fall) begin
          miso_clear = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit counter and receive shift registers; cleared at every frame boundary
  // so a partial frame leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      cmd_shift  <= '0;
      data_shift <= '0;
    end else if (frame_start || frame_end) begin
      bit_cnt    <= '0;
      cmd_shift  <= '0;
      data_shift <= '0;
    end else begin
      if (cmd_shift_en || data_shift_en) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (cmd_shift_en) begin
        cmd_shift <= cmd_word_next;
      end
      if (data_shift_en) begin
        data_shift <= {data_shift[30:0], mosi_old};
      end
    end
  end

  // Read path: snapshot on the last command bit, then present one bit per
  // sck falling edge; miso stays low for writes, bad commands and outside data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift  <= '0;
      tx_active <= 1'b0;
      miso_q    <= 1'b0;
    end else if (frame_start || frame_end) begin
      tx_shift  <= '0;
      tx_active <= 1'b0;
      miso_q    <= 1'b0;
    end else if (snapshot_load) begin
      tx_shift  <= read_snapshot(cmd_word_next[3:0], rd_reg);
      tx_active <= ~cmd_word_next[7] & cmd_reserved_ok(cmd_word_next);
      miso_q    <= 1'b0;
    end else if (tx_step) begin
      if (tx_active) begin
        miso_q   <= tx_shift[31];
        tx_shift <= {tx_shift[30:0], 1'b0};
      end else begin
        miso_q <= 1'b0;
      end
    end else if (miso_clear) begin
      miso_q <= 1'b0;
    end
  end

  assign spi.spi_miso = miso_q;

  // Write path: latch the complete word on the 40th rise, publish it on the
  // following cycle with a toggle. The latch keeps the commit independent of
  // a new frame starting in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_data    <= '0;
      commit_addr    <= '0;
      commit_pending <= 1'b0;
      wr_reg         <= '0;
      wr_reg_addr    <= '0;
      wr_reg_changed <= 1'b0;
    end else begin
      if (write_capture) begin
        commit_data    <= {data_shift[30:0], mosi_old};
        commit_addr    <= cmd_shift[3:0];
        commit_pending <= 1'b1;
      end else if (commit_pending) begin
        wr_reg         <= commit_data;
        wr_reg_addr    <= commit_addr;
        wr_reg_changed <= ~wr_reg_changed;
        commit_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge: MCU-side SPI mode-0 frames
// at clk = 10 x sck, with hand-computed expected register and miso values.
module tb_spi_reg_bridge;
  import spi_reg_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed;
  logic [31:0] rd_reg;
  logic        fpga_irq;
  logic        mcu_irq;

  int vectors     = 0;
  int miscompares = 0;
  int toggles     = 0;
  int base        = 0;
  int reset_at_bit = -1;

  logic        prev_changed = 1'b0;
  logic [31:0] rx_word;
  logic        miso_any;
  logic        miso_cmd;

  spi_reg_bridge_if bus ();

  spi_reg_bridge #(
    .SYNC_STAGES   (3),
    .CLK_RATIO_MIN (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi            (bus),
    .wr_reg         (wr_reg),
    .wr_reg_addr    (wr_reg_addr),
    .wr_reg_changed (wr_reg_changed),
    .rd_reg         (rd_reg),
    .fpga_irq       (fpga_irq),
    .mcu_irq        (mcu_irq)
  );

  // System clock.
  always #5 clk = ~clk;

  // Count every change of the write toggle, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_reg_changed !== prev_changed) toggles++;
    prev_changed = wr_reg_changed;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Half an sck period (5 clk), watching miso on every falling clk edge.
  task automatic halfBit(input bit in_cmd);
    repeat (5) begin
      @(negedge clk);
      if (bus.spi_miso !== 1'b0) begin
        miso_any = 1'b1;
        if (in_cmd) miso_cmd = 1'b1;
      end
    end
  endtask

  // One MCU frame of nbits bits: command, data, then 0xFF filler bits.
  // Collects the 32 bits of miso seen at the rises of bits 8..39.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] data,
                               input int nbits);
    logic [47:0] bits;
    bits     = {cmd, data, 8'hFF};
    rx_word  = '0;
    miso_any = 1'b0;
    miso_cmd = 1'b0;
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    halfBit(1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at_bit) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_wr_reg", wr_reg, 32'h0);
        checkOutput("midreset_addr", {28'h0, wr_reg_addr}, 32'h0);
        checkOutput("midreset_changed", {31'h0, wr_reg_changed}, 32'h0);
        checkOutput("midreset_miso", {31'h0, bus.spi_miso}, 32'h0);
        reset_n = 1'b1;
      end
      bus.spi_mosi = bits[47-i];
      halfBit(i < 8);
      bus.spi_sck = 1'b1;
      if (i >= 8 && i < 40) rx_word = {rx_word[30:0], bus.spi_miso};
      halfBit(i < 8);
      bus.spi_sck = 1'b0;
    end
    halfBit(1'b0);
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    halfBit(1'b0);
    halfBit(1'b0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    rd_reg       = 32'h0000_0005;
    fpga_irq     = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_wr_reg", wr_reg, 32'h0);
    checkOutput("rst_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("rst_changed", {31'h0, wr_reg_changed}, 32'h0);
    checkOutput("rst_miso", {31'h0, bus.spi_miso}, 32'h0);
    checkOutput("rst_mcu_irq", {31'h0, mcu_irq}, 32'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] write 0x80 / 0x00000A41");
    base = toggles;
    applyStimulus({1'b1, 3'b000, REG_MAPPER}, 32'h0000_0A41, 40);
    checkOutput("w1_wr_reg", wr_reg, 32'h0000_0A41);
    checkOutput("w1_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("w1_changed", {31'h0, wr_reg_changed}, 32'h1);
    checkOutput("w1_toggles", toggles - base, 32'd1);
    checkOutput("w1_miso_zero", {31'h0, miso_any}, 32'h0);

    $display("[TB] reads of status, id and an unmapped address");
    base = toggles;
    applyStimulus(8'h00, 32'h0, 40);
    checkOutput("rd_status", rx_word, 32'h0000_0005);
    checkOutput("rd_status_cmd_miso", {31'h0, miso_cmd}, 32'h0);
    applyStimulus(8'h0F, 32'h0, 40);
    checkOutput("rd_id", rx_word, 32'hFCA7_0001);
    applyStimulus(8'h03, 32'h0, 40);
    checkOutput("rd_unmapped", rx_word, 32'h0);
    checkOutput("rd_miso_zero", {31'h0, miso_any}, 32'h0);
    checkOutput("rd_no_toggle", toggles - base, 32'd0);
    checkOutput("rd_wr_reg_kept", wr_reg, 32'h0000_0A41);

    $display("[TB] aborted write then full write to loader");
    base = toggles;
    applyStimulus({1'b1, 3'b000, REG_LOADER}, 32'hFFFF_FFFF, 20);
    checkOutput("part_wr_reg", wr_reg, 32'h0000_0A41);
    checkOutput("part_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("part_changed", {31'h0, wr_reg_changed}, 32'h1);
    checkOutput("part_toggles", toggles - base, 32'd0);
    applyStimulus({1'b1, 3'b000, REG_LOADER}, 32'h0000_0003, 40);
    checkOutput("w2_wr_reg", wr_reg, 32'h0000_0003);
    checkOutput("w2_addr", {28'h0, wr_reg_addr}, 32'h1);
    checkOutput("w2_changed", {31'h0, wr_reg_changed}, 32'h0);
    checkOutput("w2_toggles", toggles - base, 32'd1);

    $display("[TB] reserved bits set");
    base = toggles;
    applyStimulus(8'h90, 32'hDEAD_BEEF, 40);
    checkOutput("rsv_w_wr_reg", wr_reg, 32'h0000_0003);
    checkOutput("rsv_w_addr", {28'h0, wr_reg_addr}, 32'h1);
    checkOutput("rsv_w_miso", {31'h0, miso_any}, 32'h0);
    applyStimulus(8'h10, 32'h0, 40);
    checkOutput("rsv_r_miso", {31'h0, miso_any}, 32'h0);
    checkOutput("rsv_toggles", toggles - base, 32'd0);

    $display("[TB] write with bits beyond the 40th");
    base = toggles;
    applyStimulus(8'h82, 32'h0000_00C3, 48);
    checkOutput("long_wr_reg", wr_reg, 32'h0000_00C3);
    checkOutput("long_addr", {28'h0, wr_reg_addr}, 32'h2);
    checkOutput("long_toggles", toggles - base, 32'd1);

    $display("[TB] reset in the middle of a write");
    reset_at_bit = 30;
    applyStimulus(8'h80, 32'h5555_AAAA, 40);
    reset_at_bit = -1;
    checkOutput("postrst_wr_reg", wr_reg, 32'h0);
    checkOutput("postrst_changed", {31'h0, wr_reg_changed}, 32'h0);
    base = toggles;
    applyStimulus(8'h80, 32'h0000_1234, 40);
    checkOutput("w3_wr_reg", wr_reg, 32'h0000_1234);
    checkOutput("w3_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("w3_changed", {31'h0, wr_reg_changed}, 32'h1);
    checkOutput("w3_toggles", toggles - base, 32'd1);

    $display("[TB] back-to-back writes");
    base = toggles;
    applyStimulus(8'h80, 32'h0000_0001, 40);
    checkOutput("b2b_first", wr_reg, 32'h0000_0001);
    applyStimulus(8'h80, 32'h0000_0002, 40);
    checkOutput("b2b_wr_reg", wr_reg, 32'h0000_0002);
    checkOutput("b2b_toggles", toggles - base, 32'd2);
    checkOutput("b2b_changed", {31'h0, wr_reg_changed}, 32'h1);

    $display("[TB] interrupt pass-through");
    @(negedge clk);
    fpga_irq = 1'b1;
    @(negedge clk);
    checkOutput("irq_rise_1clk", {31'h0, mcu_irq}, 32'h0);
    @(negedge clk);
    checkOutput("irq_rise_2clk", {31'h0, mcu_irq}, 32'h1);
    fpga_irq = 1'b0;
    @(negedge clk);
    checkOutput("irq_fall_1clk", {31'h0, mcu_irq}, 32'h1);
    @(negedge clk);
    checkOutput("irq_fall_2clk", {31'h0, mcu_irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
